// File: rtl/demux_dispatch_sequencer.sv
// Buffers channel-dispatch requests in a small FIFO and plays each one out to the
// 1-to-16 demux as a fixed-width data pulse followed by an idle gap.
module demux_dispatch_sequencer #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int SEL_W        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SEL_W-1:0]               req_ch,
    input  logic                           req_data,
    output logic                           dmx_inp,
    output logic [SEL_W-1:0]               dmx_sel,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int MAXPG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAXC  = (MAXPG > 2) ? MAXPG : 2;
    localparam int CNT_W = $clog2(MAXC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [SEL_W:0]    mem [DEPTH];
    logic [SEL_W:0]    head;
    logic              push;
    logic              pop;

    // Ready depends on occupancy alone: a pop in the same cycle never frees a slot early.
    assign req_ready = (fifo_count < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_ch, req_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Select only moves on the pop edge, together with the 0->data step of dmx_inp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dmx_inp <= 1'b0;
            dmx_sel <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dmx_inp <= 1'b0;
                    if (pop) begin
                        dmx_sel <= head[SEL_W:1];
                        dmx_inp <= head[0];
                        cnt     <= CNT_W'(PULSE_CYCLES - 1);
                        busy    <= 1'b1;
                        state   <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        dmx_inp <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    dmx_inp <= 1'b0;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    dmx_inp <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_demux_dispatch_sequencer.sv
// Directed bench for demux_dispatch_sequencer: default build plus a PULSE=1/GAP=0 build,
// with a select-stability monitor and a slot scoreboard for a randomized burst.
module tb_demux_dispatch_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_data, req_ready;
    logic [3:0] req_ch;
    logic       dmx_inp, busy;
    logic [3:0] dmx_sel;
    logic [2:0] fifo_count;

    logic       req_valid2, req_data2, req_ready2;
    logic [3:0] req_ch2;
    logic       dmx_inp2, busy2;
    logic [3:0] dmx_sel2;
    logic [2:0] fifo_count2;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q [$];
    logic       sb_en = 1'b0;
    logic       prev_inp = 1'b0, prev_busy = 1'b0;
    logic [3:0] prev_sel = '0;

    demux_dispatch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_data(req_data), .dmx_inp(dmx_inp), .dmx_sel(dmx_sel),
        .busy(busy), .fifo_count(fifo_count)
    );

    demux_dispatch_sequencer #(.DEPTH(4), .PULSE_CYCLES(1), .GAP_CYCLES(0), .SEL_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_ch(req_ch2), .req_data(req_data2), .dmx_inp(dmx_inp2), .dmx_sel(dmx_sel2),
        .busy(busy2), .fifo_count(fifo_count2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ch, input logic d);
        req_valid = v;
        req_ch    = ch;
        req_data  = d;
    endtask

    // Select must not move while the data pulse is high; scoreboard checks each new slot.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_inp && dmx_inp) begin
                checks++;
                assert (dmx_sel === prev_sel) else begin
                    errors++;
                    $error("FAIL sel_stable: observed %0d expected %0d", dmx_sel, prev_sel);
                end
            end
            if (sb_en && busy && !prev_busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL sb_extra: observed slot %0d expected none", {dmx_sel, dmx_inp});
                end else begin
                    assert ({dmx_sel, dmx_inp} === exp_q[0]) else begin
                        errors++;
                        $error("FAIL sb_slot: observed %0h expected %0h", {dmx_sel, dmx_inp}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_inp  = dmx_inp;
        prev_sel  = dmx_sel;
        prev_busy = busy;
    end

    initial begin
        int acc;
        int cyc;
        logic v;
        logic [3:0] ch;
        logic d;

        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        req_valid2 = 1'b0; req_ch2 = '0; req_data2 = 1'b0;
        tick(); tick();
        chk("rst_inp", dmx_inp, 0);
        chk("rst_sel", dmx_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single request ch=5 data=1
        drive(1'b1, 4'd5, 1'b1);
        tick();
        drive(1'b0, 4'd0, 1'b0);
        chk("single_n_count", fifo_count, 1);
        chk("single_n_busy", busy, 0);
        tick();
        chk("single_n1_sel", dmx_sel, 5);
        chk("single_n1_inp", dmx_inp, 1);
        chk("single_n1_busy", busy, 1);
        chk("single_n1_count", fifo_count, 0);
        tick();
        chk("single_n2_inp", dmx_inp, 1);
        chk("single_n2_sel", dmx_sel, 5);
        tick();
        chk("single_n3_inp", dmx_inp, 0);
        chk("single_n3_busy", busy, 1);
        tick();
        chk("single_n4_busy", busy, 0);
        chk("single_n4_sel", dmx_sel, 5);
        tick();

        // Fill to full: ch1 pops immediately, five pushes fit
        drive(1'b1, 4'd1, 1'b1); tick();
        chk("fill_c1", fifo_count, 1);
        drive(1'b1, 4'd2, 1'b1); tick();
        chk("fill_c2", fifo_count, 1);
        chk("fill_sel1", dmx_sel, 1);
        chk("fill_inp1", dmx_inp, 1);
        drive(1'b1, 4'd3, 1'b1); tick();
        chk("fill_c3", fifo_count, 2);
        drive(1'b1, 4'd4, 1'b1); tick();
        chk("fill_c4", fifo_count, 3);
        drive(1'b1, 4'd5, 1'b1); tick();
        chk("fill_full", fifo_count, 4);
        chk("fill_ready0", req_ready, 0);
        drive(1'b1, 4'd6, 1'b1); tick();
        drive(1'b0, 4'd0, 1'b0);
        chk("fill_ignored", fifo_count, 3);
        chk("fill_sel2", dmx_sel, 2);
        chk("fill_inp2", dmx_inp, 1);
        for (int i = 3; i <= 5; i++) begin
            repeat (4) tick();
            chk("fill_order_sel", dmx_sel, i);
            chk("fill_order_inp", dmx_inp, 1);
            chk("fill_order_count", fifo_count, 5 - i);
        end
        repeat (4) tick();
        chk("fill_drained", busy, 0);

        // Push on the IDLE pop edge with count=2
        drive(1'b1, 4'd7, 1'b1); tick();
        drive(1'b1, 4'd8, 1'b1); tick();
        drive(1'b1, 4'd9, 1'b1); tick();
        drive(1'b0, 4'd0, 1'b0);
        chk("pp_pre_count", fifo_count, 2);
        tick(); tick();
        chk("pp_idle", busy, 0);
        drive(1'b1, 4'd10, 1'b0); tick();
        drive(1'b0, 4'd0, 1'b0);
        chk("pp_count_same", fifo_count, 2);
        chk("pp_sel8", dmx_sel, 8);
        repeat (4) tick();
        chk("pp_sel9", dmx_sel, 9);
        chk("pp_count1", fifo_count, 1);
        repeat (4) tick();
        chk("pp_sel10", dmx_sel, 10);
        chk("pp_data0_inp", dmx_inp, 0);
        chk("pp_data0_busy", busy, 1);
        repeat (4) tick();

        // Reset in the middle of a pulse with an entry queued
        drive(1'b1, 4'd3, 1'b1); tick();
        drive(1'b1, 4'd4, 1'b1); tick();
        drive(1'b0, 4'd0, 1'b0);
        chk("mid_pulse_inp", dmx_inp, 1);
        chk("mid_pulse_count", fifo_count, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inp", dmx_inp, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_sel", dmx_sel, 0);
        tick(); tick();
        chk("mid_after_busy", busy, 0);
        chk("mid_after_inp", dmx_inp, 0);

        // PULSE=1, GAP=0 build: ch15 then ch0
        req_valid2 = 1'b1; req_ch2 = 4'd15; req_data2 = 1'b1; tick();
        chk("g0_count", fifo_count2, 1);
        req_ch2 = 4'd0; tick();
        req_valid2 = 1'b0;
        chk("g0_k_sel", dmx_sel2, 15);
        chk("g0_k_inp", dmx_inp2, 1);
        chk("g0_k_busy", busy2, 1);
        tick();
        chk("g0_idle_inp", dmx_inp2, 0);
        chk("g0_idle_busy", busy2, 0);
        tick();
        chk("g0_k2_sel", dmx_sel2, 0);
        chk("g0_k2_inp", dmx_inp2, 1);
        tick();
        chk("g0_end_inp", dmx_inp2, 0);
        chk("g0_end_count", fifo_count2, 0);

        // Randomized burst against the slot scoreboard
        tick();
        sb_en = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 60 && cyc < 4000) begin
            v  = ($urandom_range(0, 3) != 0);
            ch = 4'($urandom_range(0, 15));
            d  = 1'($urandom_range(0, 1));
            drive(v, ch, d);
            if (v && req_ready) begin
                exp_q.push_back({ch, d});
                acc++;
            end
            tick();
            cyc++;
        end
        drive(1'b0, 4'd0, 1'b0);
        chk("rand_accepted", acc, 60);
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || busy); i++) tick();
        tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_final_busy", busy, 0);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
